// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port ram between instruction fetch and the
// load/store port. Data has priority, fetch is protected by a starvation
// counter, and sub-word stores become a read cycle followed by a write cycle.
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_in,
    input  logic [31:0]       ram_out
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BE_W   = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, RMW} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic [WORD_W-1:0]   merged_q, merged_d;
    logic [ADDR_W-1:0]   saved_addr_q, saved_addr_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
    logic [WORD_W-1:0]   d_rdata_q, d_rdata_d;
    logic                fetch_wins;
    logic                if_grant;
    logic                d_grant;

    assign if_ready  = if_grant;
    assign d_ready   = d_grant;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    // Arbitration, ram port drive, store merge and next-state computation.
    always_comb begin
        if_grant     = 1'b0;
        d_grant      = 1'b0;
        fetch_wins   = 1'b0;
        ram_we       = 1'b0;
        ram_address  = if_addr;
        ram_in       = d_wdata;
        state_d      = state_q;
        merged_d     = merged_q;
        saved_addr_d = saved_addr_q;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        if (state_q == RMW) begin
            // Write half of a partial store; dropped if reset is asserted now.
            ram_we      = reset;
            ram_address = saved_addr_q;
            ram_in      = merged_q;
            state_d     = IDLE;
        end else if (reset) begin
            fetch_wins = if_req && (!d_req || (starve_q == LIMIT));
            if (fetch_wins) begin
                if_grant    = 1'b1;
                if_rvalid_d = 1'b1;
                if_rdata_d  = ram_out;
            end else if (d_req) begin
                d_grant     = 1'b1;
                ram_address = d_addr;
                if (!d_we) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = ram_out;
                end else if (d_be == 4'b1111) begin
                    ram_we = 1'b1;
                end else if (d_be != 4'b0000) begin
                    saved_addr_d = d_addr;
                    for (int i = 0; i < int'(BE_W); i++) begin
                        merged_d[8*i +: 8] = d_be[i] ? d_wdata[8*i +: 8] : ram_out[8*i +: 8];
                    end
                    state_d = RMW;
                end
            end
        end

        // Count consecutive denied fetch cycles, saturating at the limit.
        if (if_req && !if_grant) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CNT_W'(1);
        end else begin
            starve_d = '0;
        end
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            merged_q     <= '0;
            saved_addr_q <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            merged_q     <= merged_d;
            saved_addr_q <= saved_addr_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a behavioural ram plus a word-level reference
// model that predicts grants, ram writes and read responses every cycle.
module tb_ram_arbiter;

    localparam int          SL = 3;
    localparam int unsigned AW = 8;
    localparam int unsigned NW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ready;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_in;
    logic [31:0]   ram_out;

    ram_arbiter #(.STARVE_LIMIT(SL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .ram_we(ram_we), .ram_address(ram_address),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    // Behavioural single-port ram: combinational read, write at clock edge.
    logic [31:0] mem [NW];
    always @(posedge clk) if (ram_we) mem[ram_address[AW-1:2]] <= ram_in;
    assign ram_out = mem[ram_address[AW-1:2]];

    // Reference model state
    logic [31:0]   ref_mem [NW];
    bit            m_rmw;
    int            m_cnt;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_merged;
    logic          e_if_rvalid, e_d_rvalid;
    logic [31:0]   e_if_rdata, e_d_rdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_if_ready, last_d_ready, last_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle,
    // advance the model across the edge, then check registered responses.
    task automatic cycle(input logic rst, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dwe, input logic [3:0] be,
                         input logic [AW-1:0] da, input logic [31:0] wd);
        logic          e_if, e_d, e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_in, rd;
        reset = rst; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_be = be; d_addr = da; d_wdata = wd;
        #3;
        e_if = 1'b0; e_d = 1'b0; e_we = 1'b0; e_addr = ia; e_in = wd;
        if (rst && m_rmw) begin
            e_we = 1'b1; e_addr = m_addr; e_in = m_merged;
        end else if (rst) begin
            if (ir && (!dr || m_cnt == SL)) e_if = 1'b1;
            else if (dr) begin
                e_d = 1'b1; e_addr = da;
                if (dwe && be == 4'hF) e_we = 1'b1;
            end
        end
        check("if_ready", 32'(if_ready), 32'(e_if));
        check("d_ready", 32'(d_ready), 32'(e_d));
        check("ram_we", 32'(ram_we), 32'(e_we));
        if (rst) check("ram_address", 32'(ram_address), 32'(e_addr));
        if (e_we) check("ram_in", ram_in, e_in);
        last_if_ready = if_ready; last_d_ready = d_ready; last_we = ram_we;
        @(posedge clk); #1;
        if (!rst) begin
            m_rmw = 0; m_cnt = 0; m_addr = '0; m_merged = '0;
            e_if_rvalid = 1'b0; e_d_rvalid = 1'b0; e_if_rdata = '0; e_d_rdata = '0;
            check("rst_if_rdata", if_rdata, 32'h0);
            check("rst_d_rdata", d_rdata, 32'h0);
        end else begin
            rd = ref_mem[e_addr[AW-1:2]];
            e_if_rvalid = e_if;
            e_d_rvalid  = e_d && !dwe;
            if (e_if) e_if_rdata = rd;
            if (e_d_rvalid) e_d_rdata = rd;
            m_rmw = 0;
            if (e_d && dwe && be != 4'h0 && be != 4'hF) begin
                m_rmw = 1; m_addr = da;
                for (int b = 0; b < 4; b++)
                    m_merged[8*b +: 8] = be[b] ? wd[8*b +: 8] : rd[8*b +: 8];
            end
            if (e_we) ref_mem[e_addr[AW-1:2]] = e_in;
            m_cnt = (ir && !e_if) ? ((m_cnt < SL) ? m_cnt + 1 : SL) : 0;
        end
        check("if_rvalid", 32'(if_rvalid), 32'(e_if_rvalid));
        check("d_rvalid", 32'(d_rvalid), 32'(e_d_rvalid));
        if (e_if_rvalid) check("if_rdata", if_rdata, e_if_rdata);
        if (e_d_rvalid) check("d_rdata", d_rdata, e_d_rdata);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0);
    endtask

    logic [7:0]    gseq;
    logic [31:0]   old_word;
    logic          p_ir, p_dr, p_we, p_rst;
    logic [AW-1:0] p_ia, p_da;
    logic [3:0]    p_be;
    logic [31:0]   p_wd;

    initial begin
        for (int i = 0; i < int'(NW); i++) ref_mem[i] = '0;
        m_rmw = 0; m_cnt = 0; m_addr = '0; m_merged = '0;
        e_if_rvalid = 1'b0; e_d_rvalid = 1'b0; e_if_rdata = '0; e_d_rdata = '0;
        reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0;
        @(posedge clk); #1;

        // Reset with both requests high
        cycle(1'b0, 1'b1, AW'(8'h04), 1'b1, 1'b0, 4'h0, AW'(8'h08), 32'h0);
        cycle(1'b0, 1'b1, AW'(8'h04), 1'b1, 1'b0, 4'h0, AW'(8'h08), 32'h0);
        idle();

        // Preload every word through full stores
        for (int w = 0; w < int'(NW); w++)
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'hF, AW'(w * 4), $urandom);
        idle();

        // Full store then load of the same word
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'hF, AW'(8'h10), 32'hDEADBEEF);
        check("full_store_we", 32'(last_we), 32'h1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 4'h0, AW'(8'h10), 32'h0);
        check("full_store_load", d_rdata, 32'hDEADBEEF);
        idle();

        // Byte merge with both ports requesting during the write cycle
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'hF, AW'(8'h20), 32'h11223344);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'b0101, AW'(8'h20), 32'hAABBCCDD);
        check("merge_read_we", 32'(last_we), 32'h0);
        cycle(1'b1, 1'b1, AW'(8'h00), 1'b1, 1'b0, 4'h0, AW'(8'h20), 32'h0);
        check("merge_rmw_we", 32'(last_we), 32'h1);
        check("merge_rmw_ready", 32'({last_if_ready, last_d_ready}), 32'h0);
        check("merge_ram_word", mem[8], 32'h11BB33DD);
        cycle(1'b1, 1'b1, AW'(8'h00), 1'b1, 1'b0, 4'h0, AW'(8'h20), 32'h0);
        check("merge_load", d_rdata, 32'h11BB33DD);
        idle();

        // Tie arbitration: data wins three times, then fetch once
        gseq = '0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, AW'(8'h04), 1'b1, 1'b0, 4'h0, AW'(8'h08), 32'h0);
            gseq = {gseq[6:0], last_d_ready};
        end
        check("tie_grant_seq", 32'(gseq), 32'h000000EE);
        idle();

        // Empty byte-enable store: accepted, no write
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'hF, AW'(8'h30), 32'h5);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'h0, AW'(8'h30), 32'hFFFFFFFF);
        check("be0_ready", 32'(last_d_ready), 32'h1);
        check("be0_we", 32'(last_we), 32'h0);
        idle();
        check("be0_ram_word", mem[12], 32'h5);

        // Reset asserted in the write cycle of a partial store
        old_word = ref_mem[16];
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'b0011, AW'(8'h40), 32'hCAFEF00D);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0);
        check("rst_rmw_we", 32'(last_we), 32'h0);
        idle();
        check("rst_rmw_ram_word", mem[16], old_word);

        // Random traffic; requesters hold their request until accepted
        p_ir = 1'b0; p_dr = 1'b0; p_we = 1'b0; p_ia = '0; p_da = '0; p_be = '0; p_wd = '0;
        for (int k = 0; k < 400; k++) begin
            if (!p_ir) begin
                p_ir = ($urandom_range(0, 2) != 0);
                p_ia = AW'($urandom_range(0, NW - 1) * 4);
            end
            if (!p_dr) begin
                p_dr = ($urandom_range(0, 3) != 0);
                p_we = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       p_be = 4'hF;
                    1:       p_be = 4'h0;
                    default: p_be = 4'($urandom);
                endcase
                p_da = AW'($urandom_range(0, NW - 1) * 4);
                p_wd = $urandom;
            end
            p_rst = ($urandom_range(0, 49) != 0);
            cycle(p_rst, p_ir, p_ia, p_dr, p_we, p_be, p_da, p_wd);
            if (last_if_ready) p_ir = 1'b0;
            if (last_d_ready) p_dr = 1'b0;
        end
        idle();
        idle();

        // Final ram contents against the model
        for (int i = 0; i < int'(NW); i++) check("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
